param_scan_responder: RTL and testbench

//  Synthesizable responder for parameter-introspection queries, the target side of a VPI-style

---
 rtl/param_scan_pkg.sv | 30 +++
 rtl/param_table_rom.sv | 41 ++++
 rtl/param_scan_responder.sv | 163 ++++++++++++++++
 tb/tb_param_scan_responder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_scan_pkg.sv
// param_scan_pkg
//   Shared types for the parameter-introspection responder: command and status
//   encodings carried on the request/response ports, the FSM state type and the
//   fixed width of a packed parameter name (8 ASCII chars).
//   No ports (package).
//   Related build macro: PARAM_SCAN_ERR_CNT_EN (used by param_scan_responder).
package param_scan_pkg;

    localparam int NAME_W = 64;

    typedef enum logic [1:0] {
        CMD_ITERATE   = 2'd0,
        CMD_SCAN      = 2'd1,
        CMD_GET_NAME  = 2'd2,
        CMD_GET_VALUE = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_OK             = 2'd0,
        ST_ERR_NO_ITER    = 2'd1,
        ST_ERR_BAD_HANDLE = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/param_table_rom.sv
// param_table_rom
//   Combinational handle -> {name, value} lookup over the compile-time table.
//   Entry i lives at PARAM_NAMES[i*64 +: 64] / PARAM_VALUES[i*VALUE_W +: VALUE_W]
//   and is addressed by handle i+1 (handle 0 is the null handle).
// Ports
//   handle_i  in   HANDLE_W  handle to look up
//   hit_o     out  1         handle is in 1..N_PARAMS
//   name_o    out  64        entry name (0 on miss)
//   value_o   out  VALUE_W   entry value (0 on miss)
module param_table_rom
    import param_scan_pkg::*;
#(
    parameter int N_PARAMS = 4,
    parameter int VALUE_W  = 32,
    parameter int HANDLE_W = $clog2(N_PARAMS + 2),
    // Tables are sized to at least one entry so an empty table stays legal.
    parameter logic [(N_PARAMS > 0 ? N_PARAMS : 1)*NAME_W-1:0]  PARAM_NAMES  = '0,
    parameter logic [(N_PARAMS > 0 ? N_PARAMS : 1)*VALUE_W-1:0] PARAM_VALUES = '0
) (
    input  logic [HANDLE_W-1:0] handle_i,
    output logic                hit_o,
    output logic [NAME_W-1:0]   name_o,
    output logic [VALUE_W-1:0]  value_o
);

    // Compare against every valid handle instead of indexing with handle-1,
    // so out-of-range handles never produce an out-of-bounds select.
    always_comb begin
        hit_o   = 1'b0;
        name_o  = '0;
        value_o = '0;
        for (int i = 0; i < N_PARAMS; i++) begin
            if (handle_i == HANDLE_W'(i + 1)) begin
                hit_o   = 1'b1;
                name_o  = PARAM_NAMES[i*NAME_W +: NAME_W];
                value_o = PARAM_VALUES[i*VALUE_W +: VALUE_W];
            end
        end
    end

endmodule

// File: rtl/param_scan_responder.sv
// param_scan_responder
//   Target side of an iterate/scan/get parameter-introspection protocol.
//   One transaction outstanding: IDLE (accept) -> LOOKUP (compute) -> RESP (hold).
// Ports
//   clk, rst     clock, synchronous active-high reset
//   req_valid/req_ready, req_cmd[1:0], req_handle[HANDLE_W-1:0]   request
//   rsp_valid/rsp_ready, rsp_status[1:0], rsp_handle, rsp_data[63:0] response
//   err_count[15:0]  (only with PARAM_SCAN_ERR_CNT_EN) saturating count of
//                    accepted requests answered with a non-OK status
// Build macro: PARAM_SCAN_ERR_CNT_EN enables the error counter and its port.
module param_scan_responder
    import param_scan_pkg::*;
#(
    parameter int N_PARAMS = 4,
    parameter int VALUE_W  = 32,
    parameter logic [(N_PARAMS > 0 ? N_PARAMS : 1)*NAME_W-1:0]  PARAM_NAMES  = '0,
    parameter logic [(N_PARAMS > 0 ? N_PARAMS : 1)*VALUE_W-1:0] PARAM_VALUES = '0,
    parameter int HANDLE_W = $clog2(N_PARAMS + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_cmd,
    input  logic [HANDLE_W-1:0] req_handle,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [1:0]          rsp_status,
    output logic [HANDLE_W-1:0] rsp_handle,
    output logic [63:0]         rsp_data
`ifdef PARAM_SCAN_ERR_CNT_EN
    ,
    output logic [15:0]         err_count
`endif
);

    localparam logic [HANDLE_W-1:0] N_H = HANDLE_W'(N_PARAMS);

    state_e              state_q, state_d;
    cmd_e                cmd_q;
    logic [HANDLE_W-1:0] handle_q;
    logic [HANDLE_W-1:0] cursor_q, cursor_d;
    logic                iter_q, iter_d;
    status_e             status_q, status_d;
    logic [HANDLE_W-1:0] rhandle_q, rhandle_d;
    logic [63:0]         data_q, data_d;

    logic                rom_hit;
    logic [NAME_W-1:0]   rom_name;
    logic [VALUE_W-1:0]  rom_value;

    param_table_rom #(
        .N_PARAMS     (N_PARAMS),
        .VALUE_W      (VALUE_W),
        .HANDLE_W     (HANDLE_W),
        .PARAM_NAMES  (PARAM_NAMES),
        .PARAM_VALUES (PARAM_VALUES)
    ) u_rom (
        .handle_i (handle_q),
        .hit_o    (rom_hit),
        .name_o   (rom_name),
        .value_o  (rom_value)
    );

    assign req_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_status = status_q;
    assign rsp_handle = rhandle_q;
    assign rsp_data   = data_q;

    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        iter_d    = iter_q;
        status_d  = status_q;
        rhandle_d = rhandle_q;
        data_d    = data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                state_d   = S_RESP;
                status_d  = ST_OK;
                rhandle_d = '0;
                data_d    = '0;
                case (cmd_q)
                    CMD_ITERATE: begin
                        cursor_d = '0;
                        // An empty table hands back the null iterator.
                        if (N_PARAMS > 0) begin
                            iter_d    = 1'b1;
                            rhandle_d = HANDLE_W'(1);
                        end else begin
                            iter_d    = 1'b0;
                        end
                    end
                    CMD_SCAN: begin
                        if (!iter_q) begin
                            status_d = ST_ERR_NO_ITER;
                        end else if (cursor_q < N_H) begin
                            rhandle_d = cursor_q + HANDLE_W'(1);
                            cursor_d  = cursor_q + HANDLE_W'(1);
                        end else begin
                            iter_d = 1'b0;  // end of list frees the iterator
                        end
                    end
                    CMD_GET_NAME: begin
                        if (rom_hit) data_d = rom_name;
                        else         status_d = ST_ERR_BAD_HANDLE;
                    end
                    default: begin  // CMD_GET_VALUE
                        if (rom_hit) data_d = 64'(rom_value);
                        else         status_d = ST_ERR_BAD_HANDLE;
                    end
                endcase
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_ITERATE;
            handle_q  <= '0;
            cursor_q  <= '0;
            iter_q    <= 1'b0;
            status_q  <= ST_OK;
            rhandle_q <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            iter_q    <= iter_d;
            status_q  <= status_d;
            rhandle_q <= rhandle_d;
            data_q    <= data_d;
            if (state_q == S_IDLE && req_valid) begin
                cmd_q    <= cmd_e'(req_cmd);
                handle_q <= req_handle;
            end
        end
    end

`ifdef PARAM_SCAN_ERR_CNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else if (state_q == S_LOOKUP && status_d != ST_OK && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`endif

endmodule

// File: tb/tb_param_scan_responder.sv
module tb_param_scan_responder;
    import param_scan_pkg::*;

    localparam logic [63:0]  NM_BIT   = "BIT";
    localparam logic [63:0]  NM_OTHER = "OTHER";
    localparam logic [127:0] NAMES_A  = {NM_OTHER, NM_BIT};
    localparam logic [63:0]  VALUES_A = {32'h0000_0012, 32'h0000_0001};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Common stimulus; sel routes it to DUT A (N=2, sel=0) or DUT B (N=0, sel=1).
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_cmd = 2'd0;
    logic [3:0]  req_handle = 4'd0;
    logic        rsp_ready = 1'b1;

    logic        req_ready_a, rsp_valid_a, req_ready_b, rsp_valid_b;
    logic [1:0]  rsp_status_a, rsp_status_b;
    logic [1:0]  rsp_handle_a;
    logic [0:0]  rsp_handle_b;
    logic [63:0] rsp_data_a, rsp_data_b;
`ifdef PARAM_SCAN_ERR_CNT_EN
    logic [15:0] err_count_a, err_count_b;
`endif

    wire        req_valid_a = req_valid & ~sel;
    wire        req_valid_b = req_valid & sel;
    wire        req_ready_m = sel ? req_ready_b : req_ready_a;
    wire        rsp_valid_m = sel ? rsp_valid_b : rsp_valid_a;
    wire [1:0]  rsp_status_m = sel ? rsp_status_b : rsp_status_a;
    wire [3:0]  rsp_handle_m = sel ? {3'b0, rsp_handle_b} : {2'b0, rsp_handle_a};
    wire [63:0] rsp_data_m = sel ? rsp_data_b : rsp_data_a;

    param_scan_responder #(
        .N_PARAMS(2), .VALUE_W(32), .PARAM_NAMES(NAMES_A), .PARAM_VALUES(VALUES_A)
    ) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_cmd(req_cmd), .req_handle(req_handle[1:0]),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status_a), .rsp_handle(rsp_handle_a), .rsp_data(rsp_data_a)
`ifdef PARAM_SCAN_ERR_CNT_EN
        , .err_count(err_count_a)
`endif
    );

    param_scan_responder #(
        .N_PARAMS(0), .VALUE_W(32)
    ) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_cmd(req_cmd), .req_handle(req_handle[0:0]),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status_b), .rsp_handle(rsp_handle_b), .rsp_data(rsp_data_b)
`ifdef PARAM_SCAN_ERR_CNT_EN
        , .err_count(err_count_b)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Drives one request with rsp_ready high, returns the response and the
    // number of cycles from acceptance to rsp_valid (-1 on timeout).
    task automatic txn(input logic [1:0] cmd, input logic [3:0] h,
                       output logic [1:0] st, output logic [3:0] hd,
                       output logic [63:0] dt, output int lat);
        bit acc = 0;
        st = 2'd3; hd = 4'hF; dt = '1; lat = -1;
        @(negedge clk);
        req_cmd = cmd; req_handle = h; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready_m) begin
                @(posedge clk); #1 req_valid = 1'b0; acc = 1;
                break;
            end
            @(negedge clk);
        end
        if (!acc) begin
            req_valid = 1'b0;
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready never seen, required 1");
            return;
        end
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (rsp_valid_m) begin
                lat = n; st = rsp_status_m; hd = rsp_handle_m; dt = rsp_data_m;
                break;
            end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: rsp_valid never seen, required 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready_a !== 1'b1 || rsp_valid_a !== 1'b0 || rsp_status_a !== 2'd0 ||
            rsp_handle_a !== 2'd0 || rsp_data_a !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b st=%0d h=%0d d=%h, required 1 0 0 0 0",
                     req_ready_a, rsp_valid_a, rsp_status_a, rsp_handle_a, rsp_data_a);
        end
    endtask

    task automatic test_iterate_scan();
        logic [1:0] st; logic [3:0] hd; logic [63:0] dt; int lat;
        logic [1:0] cmds [4] = '{CMD_ITERATE, CMD_SCAN, CMD_SCAN, CMD_SCAN};
        logic [3:0] exp_h [4] = '{4'd1, 4'd1, 4'd2, 4'd0};
        for (int k = 0; k < 4; k++) begin
            txn(cmds[k], 4'd0, st, hd, dt, lat);
            checks++;
            if (st !== ST_OK || hd !== exp_h[k] || dt !== 64'd0) begin
                errors++;
                $display("FAIL iter_scan[%0d]: st=%0d h=%0d d=%h, required 0 %0d 0", k, st, hd, dt, exp_h[k]);
            end
            if (k == 0) begin
                checks++;
                if (lat !== 2) begin
                    errors++;
                    $display("FAIL latency: %0d cycles, required 2", lat);
                end
            end
        end
    endtask

    task automatic test_get_after_end();
        logic [1:0] st; logic [3:0] hd; logic [63:0] dt; int lat;
        txn(CMD_SCAN, 4'd0, st, hd, dt, lat);
        checks++;
        if (st !== ST_ERR_NO_ITER || hd !== 4'd0) begin
            errors++;
            $display("FAIL scan_no_iter: st=%0d h=%0d, required 1 0", st, hd);
        end
        txn(CMD_GET_VALUE, 4'd2, st, hd, dt, lat);
        checks++;
        if (st !== ST_OK || dt !== 64'h12 || hd !== 4'd0) begin
            errors++;
            $display("FAIL get_value_h2: st=%0d d=%h, required 0 12", st, dt);
        end
        txn(CMD_GET_NAME, 4'd1, st, hd, dt, lat);
        checks++;
        if (st !== ST_OK || dt !== 64'h0000_0000_0042_4954) begin
            errors++;
            $display("FAIL get_name_h1: st=%0d d=%h, required 0 0000000000424954", st, dt);
        end
        txn(CMD_GET_NAME, 4'd2, st, hd, dt, lat);
        checks++;
        if (st !== ST_OK || dt !== 64'h0000_004F_5448_4552) begin
            errors++;
            $display("FAIL get_name_h2: st=%0d d=%h, required 0 0000004f54484552", st, dt);
        end
    endtask

    task automatic test_bad_handle();
        logic [1:0] st; logic [3:0] hd; logic [63:0] dt; int lat;
        logic [3:0] hs [2] = '{4'd0, 4'd3};
`ifdef PARAM_SCAN_ERR_CNT_EN
        logic [15:0] e0 = err_count_a;
`endif
        for (int k = 0; k < 2; k++) begin
            txn(CMD_GET_VALUE, hs[k], st, hd, dt, lat);
            checks++;
            if (st !== ST_ERR_BAD_HANDLE || dt !== 64'd0) begin
                errors++;
                $display("FAIL bad_handle[h=%0d]: st=%0d d=%h, required 2 0", hs[k], st, dt);
            end
        end
`ifdef PARAM_SCAN_ERR_CNT_EN
        checks++;
        if (err_count_a - e0 !== 16'd2) begin
            errors++;
            $display("FAIL err_count_delta: %0d, required 2", err_count_a - e0);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [1:0] s0; logic [3:0] h0; logic [63:0] d0; bit got = 0;
        @(negedge clk);
        req_cmd = CMD_ITERATE; req_handle = 4'd0; req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1 req_cmd = CMD_SCAN;  // a second request stays pending
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid_a) begin got = 1; break; end
        end
        s0 = rsp_status_a; h0 = {2'b0, rsp_handle_a}; d0 = rsp_data_a;
        checks++;
        if (!got || s0 !== ST_OK || h0 !== 4'd1) begin
            errors++;
            $display("FAIL bp_first_rsp: vld=%b st=%0d h=%0d, required 1 0 1", got, s0, h0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid_a !== 1'b1 || req_ready_a !== 1'b0 || rsp_status_a !== s0 ||
                {2'b0, rsp_handle_a} !== h0 || rsp_data_a !== d0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b st=%0d h=%0d, required 1 0 %0d %0d",
                         k, rsp_valid_a, req_ready_a, rsp_status_a, rsp_handle_a, s0, h0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready_a !== 1'b1 || rsp_valid_a !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: rdy=%b vld=%b, required 1 0", req_ready_a, rsp_valid_a);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready_a !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept: rdy=%b, required 0 (request taken)", req_ready_a);
        end
        got = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid_a) begin got = 1; break; end
        end
        checks++;
        if (!got || rsp_status_a !== ST_OK || rsp_handle_a !== 2'd1) begin
            errors++;
            $display("FAIL bp_second_rsp: vld=%b st=%0d h=%0d, required 1 0 1", got, rsp_status_a, rsp_handle_a);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_lookup();
        logic [1:0] st; logic [3:0] hd; logic [63:0] dt; int lat;
        @(negedge clk);
        req_cmd = CMD_ITERATE; req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin
            errors++;
            $display("FAIL rst_lookup: vld=%b rdy=%b, required 0 1", rsp_valid_a, req_ready_a);
        end
        txn(CMD_SCAN, 4'd0, st, hd, dt, lat);
        checks++;
        if (st !== ST_ERR_NO_ITER || hd !== 4'd0) begin
            errors++;
            $display("FAIL rst_scan: st=%0d h=%0d, required 1 0", st, hd);
        end
    endtask

    task automatic test_empty_table();
        logic [1:0] st; logic [3:0] hd; logic [63:0] dt; int lat;
        sel = 1'b1;
        txn(CMD_ITERATE, 4'd0, st, hd, dt, lat);
        checks++;
        if (st !== ST_OK || hd !== 4'd0) begin
            errors++;
            $display("FAIL empty_iterate: st=%0d h=%0d, required 0 0", st, hd);
        end
        txn(CMD_SCAN, 4'd0, st, hd, dt, lat);
        checks++;
        if (st !== ST_ERR_NO_ITER || hd !== 4'd0) begin
            errors++;
            $display("FAIL empty_scan: st=%0d h=%0d, required 1 0", st, hd);
        end
        txn(CMD_GET_NAME, 4'd1, st, hd, dt, lat);
        checks++;
        if (st !== ST_ERR_BAD_HANDLE || dt !== 64'd0) begin
            errors++;
            $display("FAIL empty_get: st=%0d d=%h, required 2 0", st, dt);
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_iterate_scan();
        test_get_after_end();
        test_bad_handle();
        test_backpressure();
        test_reset_in_lookup();
        test_empty_table();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
